// File: rtl/mmu_result_uart_tx.sv
// mmu_result_uart_tx: drains 64-bit MMU result words and sends them to the
// host as 8N1 UART bytes on a single TX pin.
//
// Each accepted word is sent as NBYTES bytes, most significant byte first
// (byte 0 = res_data[0:7]). Within a byte, bits go out LSB first, so
// res_data[8k+7] is the first data bit of byte k.
//
// Optional feature macro: MMU_TX_CHECKSUM_EN. When it is defined, one more
// byte follows the data bytes: the XOR of all data bytes.
//
// Ports:
//   D_CLK      system clock, rising edge
//   D_OFF      synchronous active-high reset
//   res_data   result word, ascending range (bit 0 = MSB)
//   res_valid  res_data holds a word to send
//   res_ready  block can accept a word this cycle (IDLE and not in reset)
//   TX         UART serial out, idle high (registered)
//   busy       a frame is in progress (registered)
module mmu_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WORD_W       = 64
) (
  input  logic              D_CLK,
  input  logic              D_OFF,
  input  logic [0:WORD_W-1] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              TX,
  output logic              busy
);

  localparam int unsigned NBYTES   = WORD_W / 8;
`ifdef MMU_TX_CHECKSUM_EN
  localparam int unsigned TX_BYTES = NBYTES + 1;
`else
  localparam int unsigned TX_BYTES = NBYTES;
`endif
  localparam int unsigned TX_W     = TX_BYTES * 8;
  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
  // One spare count keeps the width non-zero for a single-byte frame.
  localparam int unsigned BYTE_W   = $clog2(TX_BYTES + 1);

  localparam logic [BAUD_W-1:0] BaudLast = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] ByteLast = BYTE_W'(TX_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  // Byte on the wire is always shreg[0:7]; the register shifts up one byte
  // at the end of every stop bit.
  logic [0:TX_W-1]   shreg_q, shreg_d;
  logic [0:TX_W-1]   load_word;
  logic [7:0]        cur_byte;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              baud_wrap;
  logic              handshake;

`ifdef MMU_TX_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      csum = csum ^ res_data[8*k +: 8];
    end
  end

  assign load_word = {res_data, csum};
`else
  assign load_word = res_data;
`endif

  assign res_ready = (state_q == StIdle) && !D_OFF;
  assign handshake = res_valid && res_ready;
  assign baud_wrap = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StStart;
          shreg_d = load_word;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      StStart: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          shreg_d = shreg_q << 8;
          if (byte_q == ByteLast) begin
            state_d = StIdle;
          end else begin
            state_d = StStart;
            byte_d  = byte_q + BYTE_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // TX is decoded from next-state values so the pin comes straight off a flop.
  always_comb begin
    cur_byte = shreg_d[0:7];
    tx_d     = 1'b1;
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_d];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge D_CLK) begin
    if (D_OFF) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign TX   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mmu_result_uart_tx.sv
// Testbench for mmu_result_uart_tx with CLKS_PER_BIT=4, WORD_W=64.
// Expected bytes are queued when a word is driven; a UART receiver process
// decodes TX and compares each byte against the head of the queue.
module tb_mmu_result_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 8;
`ifdef MMU_TX_CHECKSUM_EN
  localparam int TXB = NB + 1;
`else
  localparam int TXB = NB;
`endif
  localparam int WORD_CYC = TXB * 10 * CPB;

  logic        clk = 1'b0;
  logic        d_off;
  logic [0:63] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        tx;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  q_exp[$];
  int          rx_count = 0;

  mmu_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .WORD_W      (64)
  ) dut (
    .D_CLK    (clk),
    .D_OFF    (d_off),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .TX       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    logic [7:0] cs;
    cs = 8'h00;
    for (int k = 0; k < NB; k++) begin
      q_exp.push_back(w[63-8*k -: 8]);
      cs = cs ^ w[63-8*k -: 8];
    end
`ifdef MMU_TX_CHECKSUM_EN
    q_exp.push_back(cs);
`endif
  endtask

  // Counts busy cycles from the current one; records TX for the first 40.
  task automatic measure(output int cnt, output logic [39:0] wave);
    cnt  = 0;
    wave = '1;
    @(negedge clk);
    while (busy === 1'b1 && cnt < WORD_CYC + 20) begin
      if (cnt < 40) wave[cnt] = tx;
      cnt++;
      tick();
      @(negedge clk);
    end
  endtask

  // UART receiver: one sample per cycle, each bit must hold for CPB cycles.
  initial begin : monitor
    logic       rx_active;
    int         rx_cyc;
    int         bidx;
    logic [9:0] frame;
    logic       glitch;
    logic [7:0] exp_byte;
    rx_active = 1'b0;
    rx_cyc    = 0;
    frame     = '0;
    glitch    = 1'b0;
    forever begin
      @(negedge clk);
      if (d_off !== 1'b0) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active && tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cyc    = 0;
          glitch    = 1'b0;
        end
        if (rx_active) begin
          bidx = rx_cyc / CPB;
          if (rx_cyc % CPB == 0) frame[bidx] = tx;
          else if (tx !== frame[bidx]) glitch = 1'b1;
          if (rx_cyc == 10 * CPB - 1) begin
            rx_active = 1'b0;
            rx_count++;
            check("rx_start_bit", 64'(frame[0]), 64'(0));
            check("rx_stop_bit", 64'(frame[9]), 64'(1));
            check("rx_bit_stable", 64'(glitch), 64'(0));
            check("rx_byte_expected", 64'(q_exp.size() != 0), 64'(1));
            if (q_exp.size() != 0) begin
              exp_byte = q_exp.pop_front();
              check("rx_byte", 64'(frame[8:1]), 64'(exp_byte));
            end
          end else begin
            rx_cyc++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          cnt;
    int          bad;
    int          rx_mark;
    logic [39:0] wave;
    logic [39:0] exp_wave;
    logic [7:0]  b01;
    logic        bv;

    d_off     = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(res_ready), 64'(0));
    tick();
    d_off = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(res_ready), 64'(1));
    check("post_rst_tx", 64'(tx), 64'(1));
    check("post_rst_busy", 64'(busy), 64'(0));
    bad = 0;
    repeat (100) begin
      tick();
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || res_ready !== 1'b1) bad++;
    end
    check("idle_hold_100", 64'(bad), 64'(0));

    // Word 0x0102030405060708
    tick();
    res_data  = 64'h0102030405060708;
    res_valid = 1'b1;
    push_word(64'h0102030405060708);
    @(negedge clk);
    check("w1_ready", 64'(res_ready), 64'(1));
    tick();
    res_valid = 1'b0;
    res_data  = 64'h0;
    measure(cnt, wave);
    check("w1_busy_cycles", 64'(cnt), 64'(WORD_CYC));
    check("w1_ready_after", 64'(res_ready), 64'(1));
    check("w1_queue_drained", 64'(q_exp.size()), 64'(0));
    b01 = 8'h01;
    for (int b = 0; b < 10; b++) begin
      bv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : b01[b-1];
      for (int p = 0; p < CPB; p++) exp_wave[b*CPB+p] = bv;
    end
    check("byte01_wire", 64'(wave), 64'(exp_wave));

    // Valid toggling with new data while busy is ignored; held word taken once
    tick();
    res_data  = 64'h1122334455667788;
    res_valid = 1'b1;
    push_word(64'h1122334455667788);
    @(negedge clk);
    check("w2_ready", 64'(res_ready), 64'(1));
    tick();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      res_valid = (i % 2 == 1);
      res_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      if (res_ready !== 1'b0) bad++;
      tick();
    end
    check("w2_ready_low_busy", 64'(bad), 64'(0));
    res_valid = 1'b1;
    res_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    push_word(64'hFFFF_FFFF_FFFF_FFFF);
    measure(cnt, wave);
    check("w2_busy_remaining", 64'(cnt), 64'(WORD_CYC - 30));
    check("held_ready", 64'(res_ready), 64'(1));
    tick();
    res_valid = 1'b0;
    measure(cnt, wave);
    check("held_tx_low_next", 64'(wave[0]), 64'(0));
    check("held_busy_cycles", 64'(cnt), 64'(WORD_CYC));
    bad = 0;
    repeat (20) begin
      tick();
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("held_no_recapture", 64'(bad), 64'(0));
    check("w2_queue_drained", 64'(q_exp.size()), 64'(0));

    // Reset in the middle of byte 3
    tick();
    res_data  = 64'hDEADBEEFCAFEF00D;
    res_valid = 1'b1;
    push_word(64'hDEADBEEFCAFEF00D);
    tick();
    res_valid = 1'b0;
    rx_mark   = rx_count;
    repeat (140) tick();
    d_off = 1'b1;
    q_exp.delete();
    @(negedge clk);
    check("midrst_ready", 64'(res_ready), 64'(0));
    tick();
    d_off = 1'b0;
    @(negedge clk);
    check("midrst_tx", 64'(tx), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ready_after", 64'(res_ready), 64'(1));
    repeat (10) tick();
    check("midrst_bytes_done", 64'(rx_count), 64'(rx_mark + 3));

    tick();
    res_data  = 64'hA5A5A5A5A5A5A5A5;
    res_valid = 1'b1;
    push_word(64'hA5A5A5A5A5A5A5A5);
    @(negedge clk);
    check("a5_ready", 64'(res_ready), 64'(1));
    tick();
    res_valid = 1'b0;
    measure(cnt, wave);
    check("a5_busy_cycles", 64'(cnt), 64'(WORD_CYC));
    check("a5_queue_drained", 64'(q_exp.size()), 64'(0));
    check("rx_total_bytes", 64'(rx_count), 64'(4 * TXB + 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmu_result_uart_tx.md
Name: mmu_result_uart_tx

Overview:
Drains 64-bit result words produced by the matrix-multiply unit and transmits them to the host as 8N1 UART bytes on a single TX pin.
- Consumer end of the MMU result interface: MMU asserts a word with valid, this block accepts it with ready, then serializes it.
- Instantiated in top next to the mmu instance; its TX pin drives the board UART.

Parameters:
CLKS_PER_BIT, 868, D_CLK cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
WORD_W, 64, result word width; must be a multiple of 8. NBYTES = WORD_W/8.

Ports:
D_CLK  input  1  system clock; all logic on rising edge
D_OFF  input  1  reset, synchronous, active-high
res_data  input  [0:WORD_W-1]  result word from MMU (ascending range, bit 0 = most significant)
res_valid  input  1  res_data holds a word to send
res_ready  output  1  block can accept a word this cycle
TX  output  1  UART serial out, idle high
busy  output  1  a frame is in progress

Behaviour:
- Reset (D_OFF=1 at a clock edge): state=IDLE, TX=1, busy=0, res_ready=0 during the reset cycle and 1 from the first cycle after D_OFF falls. Baud, bit and byte counters cleared.
- Reset mid-frame: the frame aborts; TX=1 on the next cycle; no partial byte completes.
- Handshake: a transfer occurs on an edge where res_valid && res_ready. The word is latched into an internal shift register; res_data may change afterwards with no effect.
- res_ready = 1 only in IDLE and not in reset. res_valid while busy is ignored and nothing is captured. The MMU holds res_valid until it sees ready.
- States:
  - IDLE: TX=1, busy=0. On handshake, go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each for CLKS_PER_BIT cycles, then STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. If more bytes remain, go to START for the next byte; otherwise go to IDLE.
- Timing:
  - TX goes low in the cycle after the handshake edge.
  - busy is 1 from that cycle through the last stop-bit cycle.
  - res_ready returns to 1 in the cycle after the last stop-bit cycle.
  - There is no idle gap between bytes.
- Byte order: byte k (k = 0..NBYTES-1) = res_data[8k : 8k+7], with res_data[8k] as that byte's MSB. Byte 0 is sent first (big-endian).
- Bit order: each byte is sent LSB-first per UART convention, so res_data[8k+7] is the first data bit on the wire.
- Word duration: NBYTES × 10 × CLKS_PER_BIT cycles. A back-to-back word sees exactly 1 IDLE cycle between frames, because res_ready is 1 for one cycle.
- Baud counter: 0..CLKS_PER_BIT-1, wraps at terminal count and advances the bit/state on wrap. Counter width is $clog2(CLKS_PER_BIT).

Optional Feature:
MMU_TX_CHECKSUM_EN
- Defined: after the NBYTES data bytes, one extra byte is framed and sent: the XOR of all NBYTES data bytes. Word duration becomes (NBYTES+1) × 10 × CLKS_PER_BIT cycles; busy and res_ready timing extend accordingly.
- Undefined: exactly NBYTES bytes per word, with no checksum logic synthesized.

Test Plan:
1. CLKS_PER_BIT=4. Release D_OFF, hold res_valid=0 → TX=1, busy=0, res_ready=1 from the cycle after reset drops; TX stays high for 100 cycles.
2. Present 0x0102030405060708 with valid → capture in 1 cycle; TX low the next cycle. Decoded bytes are 01,02,…,08. Each bit is held 4 cycles. busy is high for 320 cycles; res_ready is 1 on cycle 321.
3. Byte 0x01 → wire sequence start 0, data 1,0,0,0,0,0,0,0, stop 1, each exactly 4 cycles.
4. During transmit, toggle res_valid and change res_data to 0xFFFF_FFFF_FFFF_FFFF → no capture, transmitted bytes unchanged. The held word is accepted exactly once, 1 cycle after the frame ends.
5. Assert D_OFF for 1 cycle in the middle of byte 3 → TX=1 and busy=0 the next cycle, res_ready=1 after. A new word 0xA5… then transmits cleanly.
6. With MMU_TX_CHECKSUM_EN, word 0x0102030405060708 → 9 bytes, the last being 0x08. busy is high for 360 cycles. Without the macro → 8 bytes, 320 cycles.
